// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
package serial_add_pkg;

    // Controller states: waiting for a request, shifting bits, presenting the result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the bit counter; it only has to reach WIDTH-1, never WIDTH
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_slice.sv
// Full-adder slice shared across every bit position of the serial add.
// It is composed of two half_adder cells and an OR gate.

// Single half-adder cell: propagate-style sum and generate-style carry
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    // Pure combinational half-add
    always_comb begin
        s = a ^ b;
        c = a & b;
    end

endmodule

// Full-adder slice: first cell adds the operand bits, second folds in the carry
module serial_fa_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic prop;
    logic gen;
    logic carry_prop;

    half_adder u_ha_ops (
        .a (a),
        .b (b),
        .s (prop),
        .c (gen)
    );

    half_adder u_ha_carry (
        .a (prop),
        .b (cin),
        .s (sum),
        .c (carry_prop)
    );

    // A carry leaves the slice if the operands generate one or propagate the incoming one
    always_comb begin
        cout = gen | carry_prop;
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice reused for WIDTH clocks,
// LSB first, with a start/busy/done handshake toward a host FSM.
// Optional build macro SERIAL_ADD_OVF_EN adds a signed-overflow output (ovf).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    // Partial sum collects the low WIDTH-1 bits; the MSB joins it on the final cycle
    logic [WIDTH-2:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic             s_bit;
    logic             c_next;

    serial_fa_slice u_slice (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (s_bit),
        .cout (c_next)
    );

    // New sum bit enters from the top so bit 0 ends up at the LSB after WIDTH shifts
    always_comb begin
        sum_next = {s_bit, sum_sh};
    end

    // Controller FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_sh <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= cin;
                        cnt    <= '0;
                        sum_sh <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sum_sh <= sum_next[WIDTH-1:1];
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= c_next;
                    if (cnt == LAST_BIT) begin
                        sum   <= sum_next;
                        cout  <= c_next;
`ifdef SERIAL_ADD_OVF_EN
                        ovf   <= carry ^ c_next;
`endif
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
